// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - register-file side bundle of the UART transmit path
// Optional overflow signals exist only when UART_TX_OVERFLOW_EN is defined.
interface uart_transmitter_if #(
  parameter int FIFO_DEPTH = 16
) ();
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    PWDATA;
  logic          tx_fifo_we;
  logic          tx_fifo_clr;
  logic [7:0]    LCR;
  logic [CW-1:0] tx_fifo_count;
  logic          tx_fifo_empty;
  logic          tx_fifo_full;
  logic          tx_busy;
`ifdef UART_TX_OVERFLOW_EN
  logic          tx_ovf_clr;
  logic          tx_overflow;
`endif

  modport master (
    output PWDATA, tx_fifo_we, tx_fifo_clr, LCR,
`ifdef UART_TX_OVERFLOW_EN
    output tx_ovf_clr,
    input  tx_overflow,
`endif
    input  tx_fifo_count, tx_fifo_empty, tx_fifo_full, tx_busy
  );

  modport slave (
    input  PWDATA, tx_fifo_we, tx_fifo_clr, LCR,
`ifdef UART_TX_OVERFLOW_EN
    input  tx_ovf_clr,
    output tx_overflow,
`endif
    output tx_fifo_count, tx_fifo_empty, tx_fifo_full, tx_busy
  );
endinterface

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART TX FIFO and frame serialiser paced by the baud tick
// Optional sticky overflow flag enabled by defining UART_TX_OVERFLOW_EN.
module uart_transmitter #(
  parameter int FIFO_DEPTH    = 16,
  parameter int TICKS_PER_BIT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              tx_enable,
  output logic              txd,
  uart_transmitter_if.slave rf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TICKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_e;
  state_e state_q, state_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [TW-1:0] tick_q;
  logic [2:0]    bit_q;
  logic [7:0]    data_q;
  logic [5:0]    lcr_q;

  logic       full, empty, push, pop, last_tick, last_data_bit, parity_bit;
  logic [7:0] data_mask;
  logic       unused_lcr_msb;

  assign unused_lcr_msb = rf.LCR[7];
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign push      = rf.tx_fifo_we && !full;
  assign pop       = (state_q == IDLE) && tx_enable && !empty && !rf.tx_fifo_clr;
  assign last_tick = tx_enable && (tick_q == TW'(TICKS_PER_BIT - 1));
  assign last_data_bit = (bit_q == (3'd4 + {1'b0, lcr_q[1:0]}));

  assign rf.tx_fifo_count = count_q;
  assign rf.tx_fifo_empty = empty;
  assign rf.tx_fifo_full  = full;
  assign rf.tx_busy       = (state_q != IDLE);

  always_ff @(posedge PCLK) begin
    if (PRESET || rf.tx_fifo_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (push) mem_q[wr_ptr_q] <= rf.PWDATA;
  end

  // Frame datapath: byte and line settings are frozen at the pop for the whole frame.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tick_q <= '0;
      bit_q  <= '0;
      data_q <= '0;
      lcr_q  <= '0;
    end else if (pop) begin
      tick_q <= '0;
      bit_q  <= '0;
      data_q <= mem_q[rd_ptr_q];
      lcr_q  <= rf.LCR[5:0];
    end else if (state_q != IDLE && tx_enable) begin
      tick_q <= last_tick ? '0 : tick_q + TW'(1);
      if (last_tick && state_q == DATA) bit_q <= bit_q + 3'd1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop)       state_d = START;
      START:   if (last_tick) state_d = DATA;
      DATA:    if (last_tick && last_data_bit) state_d = lcr_q[3] ? PARITY : STOP1;
      PARITY:  if (last_tick) state_d = STOP1;
      STOP1:   if (last_tick) state_d = lcr_q[2] ? STOP2 : IDLE;
      STOP2:   if (last_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign data_mask  = 8'hFF >> (2'd3 - lcr_q[1:0]);
  assign parity_bit = lcr_q[5] ? ~lcr_q[4]
                    : (lcr_q[4] ? ^(data_q & data_mask) : ~^(data_q & data_mask));

  // Break follows the live LCR so software sees it take effect at once.
  always_comb begin
    txd = 1'b1;
    case (state_q)
      START:   txd = 1'b0;
      DATA:    txd = data_q[bit_q];
      PARITY:  txd = parity_bit;
      default: txd = 1'b1;
    endcase
    if (rf.LCR[6]) txd = 1'b0;
  end

`ifdef UART_TX_OVERFLOW_EN
  logic ovf_q;

  always_ff @(posedge PCLK) begin
    if (PRESET)                         ovf_q <= 1'b0;
    else if (rf.tx_fifo_we && full)     ovf_q <= 1'b1;
    else if (rf.tx_ovf_clr)             ovf_q <= 1'b0;
  end

  assign rf.tx_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter
// Overflow checks are compiled in when UART_TX_OVERFLOW_EN is defined.
module tb_uart_transmitter;
  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  logic tx_enable = 1'b0;
  logic txd;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] fifo_q[$];
  bit         exp_bits[$];

  typedef struct {
    logic       we;
    logic       clr;
    logic [7:0] d;
    int         cnt;
    logic       emp;
    logic       full;
  } vec_t;
  vec_t vecs[7];

  uart_transmitter_if #(.FIFO_DEPTH(16)) rf ();

  uart_transmitter #(.FIFO_DEPTH(16), .TICKS_PER_BIT(16)) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .tx_enable(tx_enable),
    .txd      (txd),
    .rf       (rf)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_tick();
    tx_enable = 1'b1;
    step();
    tx_enable = 1'b0;
    repeat (3) step();
  endtask

  task automatic push(input logic [7:0] b);
    rf.PWDATA     = b;
    rf.tx_fifo_we = 1'b1;
    step();
    rf.tx_fifo_we = 1'b0;
    if (fifo_q.size() < 16) fifo_q.push_back(b);
  endtask

  // Expected serial bit list for one frame, one entry per bit period.
  task automatic build_frame(input logic [7:0] lcr, input logic [7:0] b);
    int wlen;
    int ones;
    wlen = 5 + int'(lcr[1:0]);
    ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int j = 0; j < wlen; j++) begin
      exp_bits.push_back(b[j]);
      ones += int'(b[j]);
    end
    if (lcr[3]) begin
      if (lcr[5])      exp_bits.push_back(!lcr[4]);
      else if (lcr[4]) exp_bits.push_back((ones % 2) == 1);
      else             exp_bits.push_back((ones % 2) == 0);
    end
    exp_bits.push_back(1'b1);
    if (lcr[2]) exp_bits.push_back(1'b1);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] lcr, input int clr_bit);
    logic [7:0] b;
    int bad;
    int first_k;
    logic first_v;
    if (fifo_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: model fifo empty, required a queued byte", tag);
      return;
    end
    rf.LCR = lcr;
    b = fifo_q.pop_front();
    build_frame(lcr, b);
    do_tick();
    check({tag, "_busy_start"}, int'(rf.tx_busy), 1);
    check({tag, "_count_after_pop"}, int'(rf.tx_fifo_count), fifo_q.size());
    for (int i = 0; i < exp_bits.size(); i++) begin
      bad = 0;
      first_k = 0;
      first_v = 1'b0;
      for (int k = 0; k < 16; k++) begin
        if (i == clr_bit && k == 3) begin
          rf.tx_fifo_clr = 1'b1;
          step();
          rf.tx_fifo_clr = 1'b0;
          fifo_q.delete();
          check({tag, "_count_after_clr"}, int'(rf.tx_fifo_count), 0);
        end
        if (txd !== exp_bits[i]) begin
          if (bad == 0) begin
            first_k = k;
            first_v = txd;
          end
          bad++;
        end
        do_tick();
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s_bit%0d: txd=%0b at tick %0d required %0b", tag, i, first_v, first_k, exp_bits[i]);
      end
    end
    check({tag, "_busy_end"}, int'(rf.tx_busy), 0);
    check({tag, "_txd_end"}, int'(txd), 1);
  endtask

  initial begin
    logic [7:0] lcr;
    int n;

    rf.PWDATA      = '0;
    rf.tx_fifo_we  = 1'b0;
    rf.tx_fifo_clr = 1'b0;
    rf.LCR         = 8'h03;
`ifdef UART_TX_OVERFLOW_EN
    rf.tx_ovf_clr  = 1'b0;
`endif
    repeat (3) step();
    PRESET = 1'b0;
    check("rst_count", int'(rf.tx_fifo_count), 0);
    check("rst_empty", int'(rf.tx_fifo_empty), 1);
    check("rst_full", int'(rf.tx_fifo_full), 0);
    check("rst_busy", int'(rf.tx_busy), 0);
    check("rst_txd", int'(txd), 1);
`ifdef UART_TX_OVERFLOW_EN
    check("rst_ovf", int'(rf.tx_overflow), 0);
`endif

    repeat (3) do_tick();
    check("idle_tick_busy", int'(rf.tx_busy), 0);
    check("idle_tick_txd", int'(txd), 1);

    vecs[0] = '{1'b1, 1'b0, 8'hA0, 1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'hA1, 2, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'hC3, 0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'hB0, 1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0};
    for (int v = 0; v < 7; v++) begin
      rf.tx_fifo_we  = vecs[v].we;
      rf.tx_fifo_clr = vecs[v].clr;
      rf.PWDATA      = vecs[v].d;
      step();
      rf.tx_fifo_we  = 1'b0;
      rf.tx_fifo_clr = 1'b0;
      check($sformatf("vec%0d_count", v), int'(rf.tx_fifo_count), vecs[v].cnt);
      check($sformatf("vec%0d_empty", v), int'(rf.tx_fifo_empty), int'(vecs[v].emp));
      check($sformatf("vec%0d_full", v), int'(rf.tx_fifo_full), int'(vecs[v].full));
    end

    push(8'h55);
    check("push55_count", int'(rf.tx_fifo_count), 1);
    run_frame("8N1_55", 8'h03, -1);
    check("8N1_55_empty", int'(rf.tx_fifo_empty), 1);

    push(8'h07);
    run_frame("8E1_07", 8'h1B, -1);
    push(8'h07);
    run_frame("8O1_07", 8'h0B, -1);
    push(8'h07);
    run_frame("stick_07", 8'h3B, -1);
    push(8'hFF);
    run_frame("5N2_FF", 8'h04, -1);

    for (int i = 0; i <= 16; i++) push(8'(i));
    check("fill_count", int'(rf.tx_fifo_count), 16);
    check("fill_full", int'(rf.tx_fifo_full), 1);
`ifdef UART_TX_OVERFLOW_EN
    step();
    check("ovf_set", int'(rf.tx_overflow), 1);
    rf.tx_ovf_clr = 1'b1;
    step();
    rf.tx_ovf_clr = 1'b0;
    check("ovf_clr", int'(rf.tx_overflow), 0);
`endif
    for (int i = 0; i < 16; i++) run_frame($sformatf("order%0d", i), 8'h03, -1);
    check("order_empty", int'(rf.tx_fifo_empty), 1);

    push(8'h11);
    push(8'h22);
    push(8'h33);
    rf.LCR        = 8'h03;
    rf.PWDATA     = 8'h44;
    rf.tx_fifo_we = 1'b1;
    tx_enable     = 1'b1;
    step();
    rf.tx_fifo_we = 1'b0;
    tx_enable     = 1'b0;
    check("pushpop_count", int'(rf.tx_fifo_count), 3);
    check("pushpop_busy", int'(rf.tx_busy), 1);
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
    fifo_q.delete();

    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    run_frame("midclr", 8'h03, 2);
    repeat (20) do_tick();
    check("midclr_idle_busy", int'(rf.tx_busy), 0);
    check("midclr_idle_count", int'(rf.tx_fifo_count), 0);
    check("midclr_idle_txd", int'(txd), 1);

    push(8'h55);
    fifo_q.delete();
    rf.LCR = 8'h03;
    do_tick();
    repeat (20) do_tick();
    check("brk_before", int'(txd), 1);
    rf.LCR = 8'h43;
    #1;
    check("brk_forced", int'(txd), 0);
    repeat (140) do_tick();
    check("brk_busy_end", int'(rf.tx_busy), 0);
    check("brk_consumed", int'(rf.tx_fifo_empty), 1);
    check("brk_txd_low", int'(txd), 0);
    rf.LCR = 8'h03;
    #1;
    check("brk_released", int'(txd), 1);

    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) push(8'($urandom_range(0, 255)));
      for (int j = 0; j < n; j++) begin
        lcr = 8'($urandom_range(0, 63));
        run_frame($sformatf("rnd%0d_%0d", r, j), lcr, -1);
      end
    end

    push(8'h3C);
    push(8'hC3);
    do_tick();
    repeat (20) do_tick();
    check("prst_busy_before", int'(rf.tx_busy), 1);
    PRESET = 1'b1;
    step();
    check("prst_txd", int'(txd), 1);
    check("prst_busy", int'(rf.tx_busy), 0);
    check("prst_count", int'(rf.tx_fifo_count), 0);
    check("prst_empty", int'(rf.tx_fifo_empty), 1);
    PRESET = 1'b0;
    fifo_q.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
